syn_updown_cnt: RTL



---
 rtl/syn_cnt_pkg.sv | 18 +
 rtl/syn_updown_next.sv | 60 ++++++
 rtl/syn_updown_cnt.sv | 94 +++++++++
 3 files changed

// File: rtl/syn_cnt_pkg.sv
// Shared definitions for the parametrised up/down counter: limit-mode
// encodings and the clamp helper used by the load path and parameter checks.
package syn_cnt_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Largest unsigned value representable in 'width' bits (width 1..32).
    function automatic logic [31:0] width_max(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

    // Limit 'value' to the inclusive range 0..max.
    function automatic logic [31:0] clamp_val(input logic [31:0] value, input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/syn_updown_next.sv
// Combinational next-state logic for the up/down counter. Priority is
// clr > load > en > hold; the limit flags are only raised by a count step
// that hits a range end, so ovf and unf can never be high together.
module syn_updown_next
    import syn_cnt_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_VAL   = width_max(WIDTH),
    parameter int          SATURATE  = CNT_WRAP,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_next,
    output logic             ovf_next,
    output logic             unf_next
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO_Q  = '0;
    localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

    // Out-of-range load values are pulled down to the top of the range.
    logic [WIDTH-1:0] load_clamped;
    assign load_clamped = WIDTH'(clamp_val(32'(load_val), MAX_VAL));

    // Select the next count and the limit-event flags for this edge.
    always_comb begin
        q_next   = q;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (clr) begin
            q_next = RESET_Q;
        end else if (load) begin
            q_next = load_clamped;
        end else if (en) begin
            if (up) begin
                if (q == MAX_Q) begin
                    ovf_next = 1'b1;
                    q_next   = (SATURATE == CNT_SAT) ? MAX_Q : ZERO_Q;
                end else begin
                    q_next = q + ONE_Q;
                end
            end else begin
                if (q == ZERO_Q) begin
                    unf_next = 1'b1;
                    q_next   = (SATURATE == CNT_SAT) ? ZERO_Q : MAX_Q;
                end else begin
                    q_next = q - ONE_Q;
                end
            end
        end
    end

endmodule

// File: rtl/syn_updown_cnt.sv
// Parametrised up/down counter with wrap or saturate limits, synchronous
// clear/load, and registered terminal-count and over/underflow flags.
// at_max/at_min are computed from the next count so they line up with q.
module syn_updown_cnt
    import syn_cnt_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_VAL   = width_max(WIDTH),
    parameter int          SATURATE  = CNT_WRAP,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_Q      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_Q    = WIDTH'(RESET_VAL);
    localparam logic             AT_MAX_RST = (RESET_Q == MAX_Q);
    localparam logic             AT_MIN_RST = (RESET_Q == '0);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("syn_updown_cnt: WIDTH must be in 2..32");
    end
    if (MAX_VAL < 1 || clamp_val(MAX_VAL, width_max(WIDTH)) != MAX_VAL) begin : g_bad_max
        $error("syn_updown_cnt: MAX_VAL must be in 1..2**WIDTH-1");
    end
    if (clamp_val(RESET_VAL, MAX_VAL) != RESET_VAL) begin : g_bad_reset
        $error("syn_updown_cnt: RESET_VAL must not exceed MAX_VAL");
    end

    logic [WIDTH-1:0] q_d, q_q;
    logic             ovf_d, ovf_q;
    logic             unf_d, unf_q;
    logic             at_max_d, at_max_q;
    logic             at_min_d, at_min_q;

    syn_updown_next #(
        .WIDTH     (WIDTH),
        .MAX_VAL   (MAX_VAL),
        .SATURATE  (SATURATE),
        .RESET_VAL (RESET_VAL)
    ) u_next (
        .q        (q_q),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .q_next   (q_d),
        .ovf_next (ovf_d),
        .unf_next (unf_d)
    );

    // Terminal-count flags derived from the value about to be registered.
    always_comb begin
        at_max_d = (q_d == MAX_Q);
        at_min_d = (q_d == '0);
    end

    // Count and flag registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q      <= RESET_Q;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            at_max_q <= AT_MAX_RST;
            at_min_q <= AT_MIN_RST;
        end else begin
            q_q      <= q_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign q      = q_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;

endmodule
